ex_operand_fwd: RTL and testbench

//  EX-stage operand forwarding datapath; direct downstream consumer of the registered hit flags from the forwarding unit.

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_mux.sv | 50 +++++
 rtl/ex_operand_fwd.sv | 148 ++++++++++++++
 tb/tb_ex_operand_fwd.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage operand forwarding datapath.
package fwd_pkg;

    localparam int FWD_XLEN = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fwd_state_e;

    typedef enum logic [1:0] {
        SEL_MA  = 2'd0,
        SEL_WB  = 2'd1,
        SEL_WBD = 2'd2,
        SEL_RF  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding mux for one EX operand (MA > WB > delayed WB > regfile).
// With FWD_ONEHOT_CHK_EN defined it also reports whether the hit flags are one-hot.
module fwd_mux
    import fwd_pkg::*;
#(
    parameter int XLEN = FWD_XLEN
) (
    input  logic            hit_idex,
    input  logic            hit_idma,
    input  logic            hit_idwb,
    input  logic            nohit,
    input  logic [XLEN-1:0] src_ma,
    input  logic [XLEN-1:0] src_wb,
    input  logic [XLEN-1:0] src_wbd,
    input  logic [XLEN-1:0] src_rf,
`ifdef FWD_ONEHOT_CHK_EN
    output logic            onehot_ok,
`endif
    output logic [XLEN-1:0] op
);

    fwd_sel_e sel;

    // nohit carries no priority of its own: no flag at all also means regfile.
    always_comb begin
        sel = SEL_RF;
        if (hit_idex) begin
            sel = SEL_MA;
        end else if (hit_idma) begin
            sel = SEL_WB;
        end else if (hit_idwb) begin
            sel = SEL_WBD;
        end
    end

    always_comb begin
        op = src_rf;
        case (sel)
            SEL_MA:  op = src_ma;
            SEL_WB:  op = src_wb;
            SEL_WBD: op = src_wbd;
            SEL_RF:  op = src_rf;
        endcase
    end

`ifdef FWD_ONEHOT_CHK_EN
    assign onehot_ok = $onehot({hit_idex, hit_idma, hit_idwb, nohit});
`endif

endmodule

// File: rtl/ex_operand_fwd.sv
// EX-stage operand forwarding: selects both operands, freezes them across stalls,
// flags load-use bubbles. Optional one-hot select checker under FWD_ONEHOT_CHK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | operands driven combinationally from the forwarding muxes
// ST_HOLD | stalled; operands and valid driven from hold registers
module ex_operand_fwd
    import fwd_pkg::*;
#(
    parameter int XLEN = FWD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rst_pipe,
    input  logic            stall,
    input  logic            stall_ld_ex,
    input  logic            hit_rs1_idex_ex,
    input  logic            hit_rs1_idma_ex,
    input  logic            hit_rs1_idwb_ex,
    input  logic            nohit_rs1_ex,
    input  logic            hit_rs2_idex_ex,
    input  logic            hit_rs2_idma_ex,
    input  logic            hit_rs2_idwb_ex,
    input  logic            nohit_rs2_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic [XLEN-1:0] rd_data_ma,
    input  logic [XLEN-1:0] rd_data_wb,
    output logic [XLEN-1:0] rs1_op_ex,
    output logic [XLEN-1:0] rs2_op_ex,
    output logic            op_valid_ex,
    output logic            fwd_err
);

    fwd_state_e      state_q, state_d;
    logic [XLEN-1:0] wb_dly_q;
    logic [XLEN-1:0] hold_rs1_q, hold_rs1_d;
    logic [XLEN-1:0] hold_rs2_q, hold_rs2_d;
    logic            hold_vld_q, hold_vld_d;
    logic [XLEN-1:0] mux_rs1, mux_rs2;
    logic            clr;

    assign clr = rst | rst_pipe;

`ifdef FWD_ONEHOT_CHK_EN
    logic ok_rs1, ok_rs2;
`endif

    fwd_mux #(.XLEN(XLEN)) u_mux_rs1 (
        .hit_idex  (hit_rs1_idex_ex),
        .hit_idma  (hit_rs1_idma_ex),
        .hit_idwb  (hit_rs1_idwb_ex),
        .nohit     (nohit_rs1_ex),
        .src_ma    (rd_data_ma),
        .src_wb    (rd_data_wb),
        .src_wbd   (wb_dly_q),
        .src_rf    (rs1_data_ex),
`ifdef FWD_ONEHOT_CHK_EN
        .onehot_ok (ok_rs1),
`endif
        .op        (mux_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_mux_rs2 (
        .hit_idex  (hit_rs2_idex_ex),
        .hit_idma  (hit_rs2_idma_ex),
        .hit_idwb  (hit_rs2_idwb_ex),
        .nohit     (nohit_rs2_ex),
        .src_ma    (rd_data_ma),
        .src_wb    (rd_data_wb),
        .src_wbd   (wb_dly_q),
        .src_rf    (rs2_data_ex),
`ifdef FWD_ONEHOT_CHK_EN
        .onehot_ok (ok_rs2),
`endif
        .op        (mux_rs2)
    );

    // WB value retired last cycle; frozen while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (clr) begin
            wb_dly_q <= '0;
        end else if (!stall) begin
            wb_dly_q <= rd_data_wb;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_rs1_d  = hold_rs1_q;
        hold_rs2_d  = hold_rs2_q;
        hold_vld_d  = hold_vld_q;
        rs1_op_ex   = mux_rs1;
        rs2_op_ex   = mux_rs2;
        op_valid_ex = ~stall_ld_ex;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d    = ST_HOLD;
                    hold_rs1_d = mux_rs1;
                    hold_rs2_d = mux_rs2;
                    hold_vld_d = ~stall_ld_ex;
                end
            end
            ST_HOLD: begin
                rs1_op_ex   = hold_rs1_q;
                rs2_op_ex   = hold_rs2_q;
                op_valid_ex = hold_vld_q;
                if (!stall) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_RUN;
            hold_rs1_q <= '0;
            hold_rs2_q <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_rs1_q <= hold_rs1_d;
            hold_rs2_q <= hold_rs2_d;
            hold_vld_q <= hold_vld_d;
        end
    end

`ifdef FWD_ONEHOT_CHK_EN
    logic err_q;

    // Only a live instruction in RUN is checked; bubbles and held operands are ignored.
    always_ff @(posedge clk) begin
        if (clr) begin
            err_q <= 1'b0;
        end else if (state_q == ST_RUN && !stall_ld_ex && !(ok_rs1 && ok_rs2)) begin
            err_q <= 1'b1;
        end
    end

    assign fwd_err = err_q;
`else
    assign fwd_err = 1'b0;
`endif

endmodule

// File: tb/tb_ex_operand_fwd.sv
// Directed bench for ex_operand_fwd: forwarding priority, stall hold, bubbles, flush, checker.
module tb_ex_operand_fwd;

    logic        clk = 1'b0;
    logic        rst, rst_pipe, stall, stall_ld_ex;
    logic        h1_ex, h1_ma, h1_wb, n1;
    logic        h2_ex, h2_ma, h2_wb, n2;
    logic [31:0] rs1_data, rs2_data, rd_ma, rd_wb;
    logic [31:0] rs1_op, rs2_op;
    logic        op_valid, fwd_err;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef FWD_ONEHOT_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    ex_operand_fwd dut (
        .clk             (clk),
        .rst             (rst),
        .rst_pipe        (rst_pipe),
        .stall           (stall),
        .stall_ld_ex     (stall_ld_ex),
        .hit_rs1_idex_ex (h1_ex),
        .hit_rs1_idma_ex (h1_ma),
        .hit_rs1_idwb_ex (h1_wb),
        .nohit_rs1_ex    (n1),
        .hit_rs2_idex_ex (h2_ex),
        .hit_rs2_idma_ex (h2_ma),
        .hit_rs2_idwb_ex (h2_wb),
        .nohit_rs2_ex    (n2),
        .rs1_data_ex     (rs1_data),
        .rs2_data_ex     (rs2_data),
        .rd_data_ma      (rd_ma),
        .rd_data_wb      (rd_wb),
        .rs1_op_ex       (rs1_op),
        .rs2_op_ex       (rs2_op),
        .op_valid_ex     (op_valid),
        .fwd_err         (fwd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge, then leave a settle gap before stimulus/checks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs1(input logic ex, input logic ma, input logic wb, input logic nh);
        h1_ex = ex; h1_ma = ma; h1_wb = wb; n1 = nh;
    endtask

    task automatic set_rs2(input logic ex, input logic ma, input logic wb, input logic nh);
        h2_ex = ex; h2_ma = ma; h2_wb = wb; n2 = nh;
    endtask

    initial begin
        rst = 1'b1; rst_pipe = 1'b0; stall = 1'b0; stall_ld_ex = 1'b0;
        set_rs1(0, 0, 0, 0); set_rs2(0, 0, 0, 0);
        rs1_data = '0; rs2_data = '0; rd_ma = '0; rd_wb = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_rs1", rs1_op, 32'h0);
        chk("rst_rs2", rs2_op, 32'h0);
        chk("rst_vld", {31'b0, op_valid}, 32'h1);
        chk("rst_err", {31'b0, fwd_err}, 32'h0);

        // MA forward is combinational, zero latency
        set_rs1(1, 0, 0, 0); set_rs2(0, 0, 0, 1);
        rd_ma = 32'h1111_0000; rs1_data = 32'hDEAD_0000; rs2_data = 32'h2222;
        #1;
        chk("ma_fwd_rs1", rs1_op, 32'h1111_0000);
        chk("rf_rs2", rs2_op, 32'h2222);
        chk("ma_fwd_vld", {31'b0, op_valid}, 32'h1);

        // Delayed WB: value present on WB one cycle earlier
        rd_wb = 32'hA5A5_A5A5;
        step();
        rd_wb = 32'h0000_1234;
        set_rs1(0, 1, 0, 0); set_rs2(0, 0, 1, 0);
        #1;
        chk("wbd_rs2", rs2_op, 32'hA5A5_A5A5);
        chk("wb_rs1", rs1_op, 32'h0000_1234);

        // Stall hold: MA changes while held
        set_rs1(1, 0, 0, 0); set_rs2(0, 0, 0, 1);
        rd_ma = 32'h5;
        #1;
        chk("pre_stall_rs1", rs1_op, 32'h5);
        stall = 1'b1;
        step();
        rd_ma = 32'h9;
        #1;
        chk("hold1_rs1", rs1_op, 32'h5);
        chk("hold1_vld", {31'b0, op_valid}, 32'h1);
        step();
        set_rs1(0, 0, 0, 1); rs1_data = 32'h0000_BEEF; rs2_data = 32'h3333;
        #1;
        chk("hold2_rs1", rs1_op, 32'h5);
        chk("hold2_rs2", rs2_op, 32'h2222);
        step();
        set_rs1(1, 0, 0, 0);
        #1;
        chk("hold3_rs1", rs1_op, 32'h5);
        stall = 1'b0;
        step();
        chk("run_rs1", rs1_op, 32'h9);
        chk("run_rs2", rs2_op, 32'h3333);

        // Load-use bubble, then held as a bubble
        stall_ld_ex = 1'b1;
        set_rs1(0, 0, 0, 1);
        #1;
        chk("bubble_vld", {31'b0, op_valid}, 32'h0);
        chk("bubble_rs1", rs1_op, 32'h0000_BEEF);
        stall = 1'b1;
        step();
        stall_ld_ex = 1'b0;
        #1;
        chk("bubble_hold_vld", {31'b0, op_valid}, 32'h0);
        step();
        chk("bubble_hold2_vld", {31'b0, op_valid}, 32'h0);

        // Flush while held and stalled: back to RUN, wb_dly cleared
        rst_pipe = 1'b1;
        step();
        rst_pipe = 1'b0;
        #1;
        chk("flush_vld", {31'b0, op_valid}, 32'h1);
        chk("flush_rs1_rf", rs1_op, 32'h0000_BEEF);
        set_rs1(0, 0, 1, 0);
        #1;
        chk("flush_wbd", rs1_op, 32'h0);
        stall = 1'b0;
        set_rs1(0, 0, 0, 1);
        step();

        // Priority with multiple flags; bubble so the checker stays quiet
        stall_ld_ex = 1'b1;
        rd_ma = 32'hAAAA_0001; rd_wb = 32'hBBBB_0002;
        rs1_data = 32'hCCCC_0003; rs2_data = 32'hDDDD_0004;
        set_rs1(1, 1, 1, 1); set_rs2(0, 1, 1, 0);
        #1;
        chk("prio_all_rs1", rs1_op, 32'hAAAA_0001);
        chk("prio_ma_wb_rs2", rs2_op, 32'hBBBB_0002);
        set_rs1(0, 0, 0, 0); set_rs2(0, 0, 1, 1);
        #1;
        chk("noflag_rs1", rs1_op, 32'hCCCC_0003);
        chk("prio_wbd_rs2", rs2_op, 32'h0000_1234);
        step();
        chk("bubble_no_err", {31'b0, fwd_err}, 32'h0);

        // One-hot violation on a live instruction
        stall_ld_ex = 1'b0;
        set_rs1(1, 0, 0, 1); set_rs2(0, 0, 0, 1);
        #1;
        chk("err_pre", {31'b0, fwd_err}, 32'h0);
        step();
        chk("err_set", {31'b0, fwd_err}, {31'b0, ERR_EXP});
        set_rs1(0, 0, 0, 1);
        step();
        chk("err_sticky", {31'b0, fwd_err}, {31'b0, ERR_EXP});
        rst_pipe = 1'b1;
        step();
        rst_pipe = 1'b0;
        #1;
        chk("err_clr", {31'b0, fwd_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
